netdma_irq_moderator: RTL and testbench
=======================================

Name: netdma_irq_moderator

Overview:
- Interrupt coalescing controller between the netdma CSR irq event logic and the CPU tx/rx irq lines.
- Each channel (tx, rx) collects completion events. It raises one irq when either the event-count threshold is reached or the holdoff timeout expires after the first event.
- The irq holds until the driver acknowledges it through the CSR clear bit.
- Events that arrive while an irq is outstanding are carried over into the next batch.

Parameters:
- CNT_WIDTH, 8: width of the event counters and thresholds.
- TIMER_WIDTH, 16: width of the holdoff timer and timeout values, in ticks.
- PRESCALER, 125: clk_i cycles per timer tick (1 us at 125 MHz). Must be >= 1.

Ports:
- clk_i  in  1  single clock for the block.
- rst_i  in  1  synchronous reset, active-high.
- tx_enable_i  in  1  tx channel moderation enable; 0 forces the channel to IDLE.
- rx_enable_i  in  1  rx channel moderation enable; 0 forces the channel to IDLE.
- tx_event_i  in  1  single-cycle tx completion event strobe.
- rx_event_i  in  1  single-cycle rx report-available event strobe.
- tx_ack_i  in  1  single-cycle tx irq acknowledge (CSR clear_tx_irq_status).
- rx_ack_i  in  1  single-cycle rx irq acknowledge (CSR clear_rx_irq_status).
- tx_cnt_thresh_i  in  CNT_WIDTH  tx events per irq; 0 is treated as 1.
- rx_cnt_thresh_i  in  CNT_WIDTH  rx events per irq; 0 is treated as 1.
- tx_timeout_i  in  TIMER_WIDTH  tx holdoff in ticks; 0 disables the timeout.
- rx_timeout_i  in  TIMER_WIDTH  rx holdoff in ticks; 0 disables the timeout.
- tx_irq_o  out  1  tx interrupt, level, registered.
- rx_irq_o  out  1  rx interrupt, level, registered.
- tx_batch_cnt_o  out  CNT_WIDTH  events in the current/last tx batch, latched at fire.
- rx_batch_cnt_o  out  CNT_WIDTH  events in the current/last rx batch, latched at fire.

Behaviour:
- Reset: all outputs, counters, the prescaler and the timer are 0; both channel FSMs go to IDLE. Reset has priority over everything, including a reset asserted mid-COLLECT or mid-FIRE.
- tx and rx are identical and independent; the rules below describe one channel.
- FSM states: IDLE, COLLECT, FIRE.
- IDLE:
  - On event with effective thresh = 1: go to FIRE; irq_o = 1 and batch_cnt_o = 1 on the next cycle (latency 1).
  - On any other event: go to COLLECT with count = 1, prescale = 0, timer = 0.
- COLLECT:
  - An event increments count, saturating at all-ones.
  - prescale counts 0..PRESCALER-1 and wraps; on wrap the timer increments, saturating.
  - Fire condition: (count + event) >= thresh, or (timeout != 0 and the timer reaches timeout).
  - On fire: go to FIRE, irq_o = 1 next cycle, batch_cnt_o = count including any same-cycle event, pending = 0.
  - Timing: with the first event at cycle N and no further events, irq_o rises at exactly N + timeout*PRESCALER + 1.
- FIRE:
  - irq_o is held at 1 and batch_cnt_o is stable.
  - Events increment pending, saturating.
  - On ack: irq_o = 0 next cycle.
    - pending (including a same-cycle event) = 0: go to IDLE.
    - pending >= thresh: FIRE is re-entered after exactly one deasserted cycle, with batch_cnt_o = pending.
    - otherwise: go to COLLECT with count = pending and timer/prescale cleared.
  - An ack outside FIRE is ignored.
- Config inputs are sampled every cycle. Lowering thresh below the current count in COLLECT fires on the next cycle.
- enable_i = 0: state goes to IDLE, irq_o = 0, and count/pending/timer are cleared on the next cycle. Events are dropped while disabled. batch_cnt_o holds its last value.
- Simultaneous tx and rx activity never interacts.

Test Plan:
1. thresh = 1, timeout = 0; tx event at cycle 10 -> tx_irq_o = 1 at cycle 11, tx_batch_cnt_o = 1; ack at cycle 20 -> tx_irq_o = 0 at cycle 21, FSM in IDLE.
2. thresh = 4, timeout = 0; rx events at cycles 5, 9, 12, 30 -> rx_irq_o rises at cycle 31, rx_batch_cnt_o = 4; no irq before cycle 31.
3. thresh = 8, timeout = 3, PRESCALER = 125; a single tx event at cycle 100 -> tx_irq_o rises at cycle 476, tx_batch_cnt_o = 1.
4. thresh = 2; fire, then 3 events during FIRE, then ack -> one low cycle, then re-fire with batch_cnt_o = 3. Repeat with 1 pending event -> COLLECT with count = 1, no re-fire until one more event.
5. Ack and event in the same cycle in FIRE with thresh = 2 -> COLLECT with count = 1. With thresh = 1 -> irq low for one cycle, then high with batch_cnt_o = 1.
6. rst_i or enable_i = 0 asserted mid-COLLECT with count = 3 -> next cycle IDLE, irq_o = 0. Events while enable = 0 are ignored; after re-enable, thresh = 4 requires 4 fresh events to fire.

Source files
------------

// File: rtl/netdma_irq_moderator.sv
// netdma interrupt coalescing: per-channel event batching with a count
// threshold and a holdoff timeout, one level irq per batch, held until ack.

module netdma_irq_chan #(
    parameter int CNT_WIDTH   = 8,
    parameter int TIMER_WIDTH = 16,
    parameter int PRESCALER   = 125
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic                   event_i,
    input  logic                   ack_i,
    input  logic [CNT_WIDTH-1:0]   cnt_thresh_i,
    input  logic [TIMER_WIDTH-1:0] timeout_i,
    output logic                   irq_o,
    output logic [CNT_WIDTH-1:0]   batch_cnt_o
);

    localparam int PS_W = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALER - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_FIRE
    } state_e;

    state_e                 state_q, state_d;
    // cnt_q is the batch count in COLLECT and the carried-over count in FIRE.
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   batch_q, batch_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [PS_W-1:0]        prescale_q, prescale_d;
    logic                   irq_q, irq_d;

    logic [CNT_WIDTH-1:0]   thresh_eff;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic [TIMER_WIDTH-1:0] timer_inc;
    logic                   ps_wrap;
    logic                   timeout_hit;

    // Shared datapath terms: effective threshold, saturating count, timer advance.
    always_comb begin
        thresh_eff  = (cnt_thresh_i == '0) ? CNT_WIDTH'(1) : cnt_thresh_i;
        cnt_inc     = (event_i && cnt_q != '1) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
        ps_wrap     = (prescale_q == PS_LAST);
        timer_inc   = (ps_wrap && timer_q != '1) ? timer_q + TIMER_WIDTH'(1) : timer_q;
        // Compare against the post-tick value so the irq lands exactly
        // timeout*PRESCALER cycles after the first event, plus one.
        timeout_hit = (timeout_i != '0) && (timer_inc >= timeout_i);
    end

    // Next-state and datapath update for the IDLE/COLLECT/FIRE controller.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        batch_d    = batch_q;
        timer_d    = timer_q;
        prescale_d = prescale_q;
        irq_d      = irq_q;

        if (!enable_i) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            timer_d    = '0;
            prescale_d = '0;
            irq_d      = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (event_i) begin
                        timer_d    = '0;
                        prescale_d = '0;
                        if (thresh_eff == CNT_WIDTH'(1)) begin
                            state_d = S_FIRE;
                            irq_d   = 1'b1;
                            batch_d = CNT_WIDTH'(1);
                            cnt_d   = '0;
                        end else begin
                            state_d = S_COLLECT;
                            cnt_d   = CNT_WIDTH'(1);
                        end
                    end
                end
                S_COLLECT: begin
                    if (cnt_inc >= thresh_eff || timeout_hit) begin
                        state_d    = S_FIRE;
                        irq_d      = 1'b1;
                        batch_d    = cnt_inc;
                        cnt_d      = '0;
                        timer_d    = '0;
                        prescale_d = '0;
                    end else begin
                        cnt_d      = cnt_inc;
                        timer_d    = timer_inc;
                        prescale_d = ps_wrap ? '0 : prescale_q + PS_W'(1);
                    end
                end
                S_FIRE: begin
                    cnt_d = cnt_inc;
                    if (ack_i) begin
                        irq_d      = 1'b0;
                        timer_d    = '0;
                        prescale_d = '0;
                        // A carried-over batch already at threshold fires
                        // again from COLLECT after its single low cycle.
                        state_d    = (cnt_inc == '0) ? S_IDLE : S_COLLECT;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    irq_d   = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State registers with synchronous reset taking priority.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            batch_q    <= '0;
            timer_q    <= '0;
            prescale_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            batch_q    <= batch_d;
            timer_q    <= timer_d;
            prescale_q <= prescale_d;
            irq_q      <= irq_d;
        end
    end

    assign irq_o       = irq_q;
    assign batch_cnt_o = batch_q;

endmodule

module netdma_irq_moderator #(
    parameter int CNT_WIDTH   = 8,
    parameter int TIMER_WIDTH = 16,
    parameter int PRESCALER   = 125
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   tx_enable_i,
    input  logic                   rx_enable_i,
    input  logic                   tx_event_i,
    input  logic                   rx_event_i,
    input  logic                   tx_ack_i,
    input  logic                   rx_ack_i,
    input  logic [CNT_WIDTH-1:0]   tx_cnt_thresh_i,
    input  logic [CNT_WIDTH-1:0]   rx_cnt_thresh_i,
    input  logic [TIMER_WIDTH-1:0] tx_timeout_i,
    input  logic [TIMER_WIDTH-1:0] rx_timeout_i,
    output logic                   tx_irq_o,
    output logic                   rx_irq_o,
    output logic [CNT_WIDTH-1:0]   tx_batch_cnt_o,
    output logic [CNT_WIDTH-1:0]   rx_batch_cnt_o
);

    netdma_irq_chan #(
        .CNT_WIDTH  (CNT_WIDTH),
        .TIMER_WIDTH(TIMER_WIDTH),
        .PRESCALER  (PRESCALER)
    ) u_tx (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .enable_i    (tx_enable_i),
        .event_i     (tx_event_i),
        .ack_i       (tx_ack_i),
        .cnt_thresh_i(tx_cnt_thresh_i),
        .timeout_i   (tx_timeout_i),
        .irq_o       (tx_irq_o),
        .batch_cnt_o (tx_batch_cnt_o)
    );

    netdma_irq_chan #(
        .CNT_WIDTH  (CNT_WIDTH),
        .TIMER_WIDTH(TIMER_WIDTH),
        .PRESCALER  (PRESCALER)
    ) u_rx (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .enable_i    (rx_enable_i),
        .event_i     (rx_event_i),
        .ack_i       (rx_ack_i),
        .cnt_thresh_i(rx_cnt_thresh_i),
        .timeout_i   (rx_timeout_i),
        .irq_o       (rx_irq_o),
        .batch_cnt_o (rx_batch_cnt_o)
    );

endmodule

// File: tb/tb_netdma_irq_moderator.sv
// Directed bench for netdma_irq_moderator: expected irq rises (cycle and
// batch size) are queued when stimulus is driven and checked when they occur.

module tb_netdma_irq_moderator;

    localparam int CW  = 8;
    localparam int TW  = 16;
    localparam int PRE = 125;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          tx_enable_i, rx_enable_i;
    logic          tx_event_i, rx_event_i;
    logic          tx_ack_i, rx_ack_i;
    logic [CW-1:0] tx_cnt_thresh_i, rx_cnt_thresh_i;
    logic [TW-1:0] tx_timeout_i, rx_timeout_i;
    logic          tx_irq_o, rx_irq_o;
    logic [CW-1:0] tx_batch_cnt_o, rx_batch_cnt_o;

    netdma_irq_moderator #(
        .CNT_WIDTH  (CW),
        .TIMER_WIDTH(TW),
        .PRESCALER  (PRE)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .tx_enable_i    (tx_enable_i),
        .rx_enable_i    (rx_enable_i),
        .tx_event_i     (tx_event_i),
        .rx_event_i     (rx_event_i),
        .tx_ack_i       (tx_ack_i),
        .rx_ack_i       (rx_ack_i),
        .tx_cnt_thresh_i(tx_cnt_thresh_i),
        .rx_cnt_thresh_i(rx_cnt_thresh_i),
        .tx_timeout_i   (tx_timeout_i),
        .rx_timeout_i   (rx_timeout_i),
        .tx_irq_o       (tx_irq_o),
        .rx_irq_o       (rx_irq_o),
        .tx_batch_cnt_o (tx_batch_cnt_o),
        .rx_batch_cnt_o (rx_batch_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string tag;
        int    cycle;
        int    batch;
    } exp_t;

    exp_t tx_q[$];
    exp_t rx_q[$];
    exp_t tx_e, rx_e;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic tx_prev = 1'b0;
    logic rx_prev = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic tx_pulse();
        tx_event_i = 1'b1;
        tick(1);
        tx_event_i = 1'b0;
    endtask

    task automatic rx_pulse();
        rx_event_i = 1'b1;
        tick(1);
        rx_event_i = 1'b0;
    endtask

    task automatic tx_ack();
        tx_ack_i = 1'b1;
        tick(1);
        tx_ack_i = 1'b0;
    endtask

    task automatic rx_ack();
        rx_ack_i = 1'b1;
        tick(1);
        rx_ack_i = 1'b0;
    endtask

    task automatic exp_tx(input string tag, input int lat, input int batch);
        exp_t e;
        e.tag = tag; e.cycle = cyc + lat; e.batch = batch;
        tx_q.push_back(e);
    endtask

    task automatic exp_rx(input string tag, input int lat, input int batch);
        exp_t e;
        e.tag = tag; e.cycle = cyc + lat; e.batch = batch;
        rx_q.push_back(e);
    endtask

    // Scoreboard side: every irq rise must match the oldest queued expectation.
    always @(negedge clk_i) begin
        if (!rst_i && tx_irq_o && !tx_prev) begin
            if (tx_q.size() == 0) begin
                check("tx_unexpected_irq_cycle", cyc, 0);
            end else begin
                tx_e = tx_q.pop_front();
                check({tx_e.tag, "_cycle"}, cyc, tx_e.cycle);
                check({tx_e.tag, "_batch"}, 32'(tx_batch_cnt_o), tx_e.batch);
            end
        end
        if (!rst_i && rx_irq_o && !rx_prev) begin
            if (rx_q.size() == 0) begin
                check("rx_unexpected_irq_cycle", cyc, 0);
            end else begin
                rx_e = rx_q.pop_front();
                check({rx_e.tag, "_cycle"}, cyc, rx_e.cycle);
                check({rx_e.tag, "_batch"}, 32'(rx_batch_cnt_o), rx_e.batch);
            end
        end
        tx_prev = tx_irq_o;
        rx_prev = rx_irq_o;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1;
        tx_enable_i = 1'b0; rx_enable_i = 1'b0;
        tx_event_i = 1'b0;  rx_event_i = 1'b0;
        tx_ack_i = 1'b0;    rx_ack_i = 1'b0;
        tx_cnt_thresh_i = 8'd1; rx_cnt_thresh_i = 8'd4;
        tx_timeout_i = '0;      rx_timeout_i = '0;
        tick(3);
        check("rst_tx_irq", 32'(tx_irq_o), 0);
        check("rst_rx_irq", 32'(rx_irq_o), 0);
        check("rst_tx_batch", 32'(tx_batch_cnt_o), 0);
        check("rst_rx_batch", 32'(rx_batch_cnt_o), 0);
        rst_i = 1'b0;
        tx_enable_i = 1'b1; rx_enable_i = 1'b1;
        tick(2);

        // Threshold 1: latency-1 fire, ack drops irq and returns to IDLE.
        exp_tx("t1_fire", 1, 1);
        tx_pulse();
        check("t1_irq_hi", 32'(tx_irq_o), 1);
        tick(8);
        check("t1_irq_held", 32'(tx_irq_o), 1);
        tx_ack();
        check("t1_irq_lo", 32'(tx_irq_o), 0);
        tick(3);
        check("t1_irq_stays_lo", 32'(tx_irq_o), 0);
        check("t1_batch_hold", 32'(tx_batch_cnt_o), 1);

        // Threshold 4 on rx with spread events.
        rx_pulse(); tick(3);
        rx_pulse(); tick(2);
        rx_pulse(); tick(17);
        check("t2_no_early_irq", 32'(rx_irq_o), 0);
        exp_rx("t2_fire", 1, 4);
        rx_pulse();
        check("t2_irq_hi", 32'(rx_irq_o), 1);
        rx_ack();
        check("t2_irq_lo", 32'(rx_irq_o), 0);

        // Holdoff timeout: single event, 3 ticks of PRE cycles.
        tx_cnt_thresh_i = 8'd8; tx_timeout_i = 16'd3;
        exp_tx("t3_timeout", 3 * PRE + 1, 1);
        tx_pulse();
        tick(3 * PRE - 1);
        check("t3_not_yet", 32'(tx_irq_o), 0);
        tick(1);
        check("t3_irq_hi", 32'(tx_irq_o), 1);
        tx_ack();
        tx_timeout_i = '0;

        // Carry-over: 3 pending at thresh 2 refire after one low cycle.
        tx_cnt_thresh_i = 8'd2;
        tx_pulse();
        exp_tx("t4_fire", 1, 2);
        tx_pulse();
        tx_pulse(); tx_pulse(); tx_pulse();
        check("t4_held_in_fire", 32'(tx_irq_o), 1);
        check("t4_batch_stable", 32'(tx_batch_cnt_o), 2);
        tx_ack();
        check("t4_low_cycle", 32'(tx_irq_o), 0);
        exp_tx("t4_refire", 1, 3);
        tick(1);
        check("t4_refire_hi", 32'(tx_irq_o), 1);
        tx_pulse();
        tx_ack();
        tick(5);
        check("t4_collect_no_refire", 32'(tx_irq_o), 0);
        exp_tx("t4_one_more", 1, 2);
        tx_pulse();
        tx_ack();

        // Ack and event in the same cycle.
        tx_pulse();
        exp_tx("t5_fire", 1, 2);
        tx_pulse();
        tx_ack_i = 1'b1; tx_event_i = 1'b1;
        tick(1);
        tx_ack_i = 1'b0; tx_event_i = 1'b0;
        tick(4);
        check("t5_collect_cnt1", 32'(tx_irq_o), 0);
        exp_tx("t5_second", 1, 2);
        tx_pulse();
        tx_cnt_thresh_i = 8'd1;
        tx_ack_i = 1'b1; tx_event_i = 1'b1;
        tick(1);
        tx_ack_i = 1'b0; tx_event_i = 1'b0;
        check("t5_one_low", 32'(tx_irq_o), 0);
        exp_tx("t5_refire_t1", 1, 1);
        tick(1);
        tx_ack();
        tick(1);
        check("t5_idle_lo", 32'(tx_irq_o), 0);

        // Lowering threshold below count fires next cycle; ack in COLLECT ignored.
        tx_cnt_thresh_i = 8'd8;
        tx_pulse(); tx_pulse(); tx_pulse();
        tx_ack();
        check("t7_ack_ignored", 32'(tx_irq_o), 0);
        tx_cnt_thresh_i = 8'd2;
        exp_tx("t7_lower_thresh", 1, 3);
        tick(1);
        tx_ack();

        // Reset and disable mid-COLLECT.
        tx_cnt_thresh_i = 8'd4;
        tx_pulse(); tx_pulse(); tx_pulse();
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        check("t6_rst_irq", 32'(tx_irq_o), 0);
        check("t6_rst_batch", 32'(tx_batch_cnt_o), 0);
        tx_pulse(); tx_pulse(); tx_pulse();
        check("t6_rst_cleared_cnt", 32'(tx_irq_o), 0);
        tx_enable_i = 1'b0;
        tick(1);
        for (int i = 0; i < 5; i++) tx_pulse();
        tx_enable_i = 1'b1;
        tick(1);
        tx_pulse(); tx_pulse(); tx_pulse();
        check("t6_three_fresh", 32'(tx_irq_o), 0);
        exp_tx("t6_fresh_fire", 1, 4);
        tx_pulse();
        tx_enable_i = 1'b0;
        tick(1);
        check("t6_dis_irq", 32'(tx_irq_o), 0);
        check("t6_dis_batch_hold", 32'(tx_batch_cnt_o), 4);
        tx_enable_i = 1'b1;
        tick(1);

        // Simultaneous tx/rx activity, rx threshold 0 treated as 1.
        tx_cnt_thresh_i = 8'd1; rx_cnt_thresh_i = 8'd2;
        exp_tx("t8_tx", 1, 1);
        tx_event_i = 1'b1; rx_event_i = 1'b1;
        tick(1);
        tx_event_i = 1'b0; rx_event_i = 1'b0;
        check("t8_rx_collecting", 32'(rx_irq_o), 0);
        exp_rx("t8_rx", 1, 2);
        tx_ack_i = 1'b1; rx_event_i = 1'b1;
        tick(1);
        tx_ack_i = 1'b0; rx_event_i = 1'b0;
        check("t8_tx_acked", 32'(tx_irq_o), 0);
        rx_ack();
        rx_cnt_thresh_i = 8'd0;
        exp_rx("t8_rx_thresh0", 1, 1);
        rx_pulse();
        check("t8_tx_untouched", 32'(tx_irq_o), 0);
        rx_ack();

        tick(5);
        check("tx_expected_left", tx_q.size(), 0);
        check("rx_expected_left", rx_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
